// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial bit feeder and the detector path.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to hold a count from 0 up to and including w.
    function automatic int counter_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry valid/ready buffer: load fills it, take empties it.
module word_hold_reg #(
    parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full
);

    logic [WIDTH-1:0] data_reg;
    logic             full_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else begin
            if (load) begin
                data_reg <= data_in;
            end
            // A simultaneous load and take leaves the entry occupied by the new word.
            full_reg <= load | (full_reg & ~take);
        end
    end

    assign data_out = data_reg;
    assign full     = full_reg;

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: valid/ready word input, one bit per clock out,
// with a holding register so consecutive words stream without a gap.
module serial_bit_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pause,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit,
    output logic             word_done
);

    localparam int CW = counter_width(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    count_reg;
    logic             word_done_reg;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             accept;
    logic             in_shift;
    logic             on_last;
    logic             retire;
    logic             hold_load;
    logic             hold_take;
    logic             current_bit;
    logic [WIDTH-1:0] shift_adv;

    assign in_ready  = ~hold_full;
    assign accept    = in_valid & in_ready;
    assign in_shift  = (state_reg == SHIFT);
    assign on_last   = (count_reg == CW'(1));
    assign retire    = in_shift & ~pause & on_last;
    // An accept on the retiring edge with the holding register empty bypasses it.
    assign hold_load = accept & in_shift & ~retire;
    assign hold_take = retire & hold_full;

    generate
        if (MSB_FIRST) begin : g_msb
            assign current_bit = shift_reg[WIDTH-1];
            assign shift_adv   = {shift_reg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign current_bit = shift_reg[0];
            assign shift_adv   = {1'b0, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    word_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (hold_load),
        .take    (hold_take),
        .data_in (in_data),
        .data_out(hold_data),
        .full    (hold_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            count_reg     <= '0;
            word_done_reg <= 1'b0;
        end else begin
            word_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= in_data;
                        count_reg <= CW'(WIDTH);
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!pause) begin
                        if (on_last) begin
                            word_done_reg <= 1'b1;
                            if (hold_full) begin
                                shift_reg <= hold_data;
                                count_reg <= CW'(WIDTH);
                            end else if (accept) begin
                                shift_reg <= in_data;
                                count_reg <= CW'(WIDTH);
                            end else begin
                                shift_reg <= '0;
                                count_reg <= '0;
                                state_reg <= IDLE;
                            end
                        end else begin
                            shift_reg <= shift_adv;
                            count_reg <= count_reg - CW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign serial_out   = in_shift ? current_bit : IDLE_LEVEL;
    assign serial_valid = in_shift;
    assign last_bit     = in_shift & on_last;
    assign word_done    = word_done_reg;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder (WIDTH=8, MSB first, idle level 0).
module tb_serial_bit_feeder;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       pause;
    logic       serial_out;
    logic       serial_valid;
    logic       last_bit;
    logic       word_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] det_hist;
    logic [7:0] det_mask;

    serial_bit_feeder #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pause       (pause),
        .serial_out  (serial_out),
        .serial_valid(serial_valid),
        .last_bit    (last_bit),
        .word_done   (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input logic done_exp);
        check({tag, " idle serial_valid"}, serial_valid, 1'b0);
        check({tag, " idle serial_out"}, serial_out, 1'b0);
        check({tag, " idle last_bit"}, last_bit, 1'b0);
        check({tag, " idle word_done"}, word_done, done_exp);
        check({tag, " idle in_ready"}, in_ready, 1'b1);
    endtask

    // Checks the eight cycles of word w, MSB first. Optionally presents inj
    // during bit inject_at; done_first is the word_done expected on bit 0.
    task automatic shift_word(input string tag, input logic [7:0] w, input int inject_at,
                              input logic [7:0] inj, input logic done_first);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s bit%0d serial_out", tag, i), serial_out, w[7-i]);
            check($sformatf("%s bit%0d serial_valid", tag, i), serial_valid, 1'b1);
            check($sformatf("%s bit%0d last_bit", tag, i), last_bit, (i == 7));
            check($sformatf("%s bit%0d word_done", tag, i), word_done, (i == 0) ? done_first : 1'b0);
            check($sformatf("%s bit%0d in_ready", tag, i), in_ready,
                  !(inject_at >= 0 && i > inject_at));
            det_hist = {det_hist[2:0], serial_out};
            det_mask[i] = (det_hist == 4'b1011);
            if (i == inject_at) begin
                in_data  = inj;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
        end
        $display("word %02h shifted out (%s)", w, tag);
    endtask

    task automatic send(input logic [7:0] w);
        in_data  = w;
        in_valid = 1'b1;
        check($sformatf("accept %02h in_ready", w), in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        pause    = 1'b0;
        det_hist = '0;
        det_mask = '0;

        #1;
        check_idle("reset", 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single word 1011_0010; accept on the first edge after release.
        send(8'hB2);
        shift_word("B2", 8'hB2, -1, 8'h00, 1'b0);
        check_idle("B2 end", 1'b1);
        tick();
        check_idle("B2 after", 1'b0);

        // Back-to-back words with the second held while the first shifts.
        send(8'hA5);
        shift_word("A5", 8'hA5, 0, 8'h3C, 1'b0);
        shift_word("3C", 8'h3C, -1, 8'h00, 1'b1);
        check_idle("3C end", 1'b1);
        tick();

        // Pause for three cycles on the fourth bit of F0.
        send(8'hF0);
        begin
            logic [10:0] exp_bits;
            exp_bits = 11'b111_1111_0000;
            for (int c = 0; c < 11; c++) begin
                check($sformatf("F0 c%0d serial_out", c), serial_out, exp_bits[10-c]);
                check($sformatf("F0 c%0d serial_valid", c), serial_valid, 1'b1);
                check($sformatf("F0 c%0d last_bit", c), last_bit, (c == 10));
                check($sformatf("F0 c%0d word_done", c), word_done, 1'b0);
                pause = (c >= 3 && c <= 5);
                tick();
            end
            pause = 1'b0;
        end
        $display("word f0 shifted out with 3-cycle pause");
        check_idle("F0 end", 1'b1);
        tick();

        // Asynchronous reset three bits into FF, with 55 waiting in the holding register.
        send(8'hFF);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("FF bit%0d serial_out", i), serial_out, 1'b1);
            if (i == 0) begin
                in_data  = 8'h55;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
        end
        check("FF hold full in_ready", in_ready, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async reset", 1'b0);
        $display("async reset applied mid-word");
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h01);
        shift_word("01", 8'h01, -1, 8'h00, 1'b0);
        check_idle("01 end", 1'b1);
        tick();
        check_idle("01 after", 1'b0);

        // Accept on the retiring edge with the holding register empty.
        send(8'hC3);
        shift_word("C3", 8'hC3, 7, 8'h5A, 1'b0);
        shift_word("5A", 8'h5A, -1, 8'h00, 1'b1);
        check_idle("5A end", 1'b1);
        tick();

        // Stream 1,0,1,1,0,1,0,1 into a 1011 detector; hit only on bit 3.
        det_hist = '0;
        send(8'hB5);
        shift_word("B5", 8'hB5, -1, 8'h00, 1'b0);
        check("detect mask", det_mask, 8'b0000_1000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
